// File: rtl/fir_sched_pkg.sv
// Shared types and widths for the FIR coefficient scheduler.
package fir_sched_pkg;

  localparam int unsigned COEF_W = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned RES_W  = SEL_W + CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One tap's shifter result as stored in the result bank.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] cnt;
    logic             zero;
  } tap_result_t;

endpackage

// File: rtl/tap_result_bank.sv
// Per-tap shifter result storage with valid bits and a registered read port.
module tap_result_bank
  import fir_sched_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 8,
  parameter int unsigned TAP_W    = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [TAP_W-1:0]  wr_addr_i,
  input  tap_result_t       wr_data_i,
  input  logic [TAP_W-1:0]  rd_addr_i,
  output tap_result_t       rd_data_o,
  output logic              rd_valid_o
);

  tap_result_t         mem_q [NUM_TAPS];
  logic [NUM_TAPS-1:0] valid_q;

  // Storage: a clear drops only valid bits; a same-cycle write still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      if (clr_i) begin
        valid_q <= '0;
      end
      if (wr_en_i) begin
        mem_q[wr_addr_i]   <= wr_data_i;
        valid_q[wr_addr_i] <= 1'b1;
      end
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_data_o  <= mem_q[rd_addr_i];
      rd_valid_o <= valid_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/fir_coef_scheduler.sv
// Walks the coefficient bank through the shifter one tap at a time and
// records each tap's normalised result.
module fir_coef_scheduler
  import fir_sched_pkg::*;
#(
  parameter int unsigned NUM_TAPS = 8,
  parameter int unsigned TAP_W    = $clog2(NUM_TAPS),
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr_en,
  input  logic [TAP_W-1:0]  cfg_wr_addr,
  input  logic [COEF_W-1:0] cfg_wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [COEF_W-1:0] sh_polynomial,
  output logic              sh_in_data_vld,
  input  logic [SEL_W-1:0]  sh_select_line,
  input  logic              sh_select_line_vld,
  input  logic [CNT_W-1:0]  sh_shift_count,
  input  logic              sh_polynomial_zero,
  input  logic [TAP_W-1:0]  rd_addr,
  output logic [SEL_W-1:0]  rd_select_line,
  output logic [CNT_W-1:0]  rd_shift_count,
  output logic              rd_zero,
  output logic              rd_valid
);

  localparam int unsigned      WCNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_idx_q, tap_idx_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [COEF_W-1:0]  coef_q [NUM_TAPS];
  logic [COEF_W-1:0]  coef_d [NUM_TAPS];
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [COEF_W-1:0]  poly_q, poly_d;
  logic               req_q, req_d;
  logic               res_wr_c;
  logic               res_clr_c;
  tap_result_t        res_wdata_c;
  tap_result_t        rd_data_c;

  // Next-state, bank updates and registered-output next values.
  always_comb begin
    state_d    = state_q;
    tap_idx_d  = tap_idx_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
    coef_d     = coef_q;
    res_wr_c   = 1'b0;
    res_clr_c  = 1'b0;

    // Config writes only land while idle; a write alongside start is
    // visible to the pass it starts because ISSUE reads coef_d.
    if (cfg_wr_en && (state_q == ST_IDLE)) begin
      coef_d[cfg_wr_addr] = cfg_wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tap_idx_d = '0;
          res_clr_c = 1'b1;
          error_d   = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (sh_select_line_vld) begin
          res_wr_c = 1'b1;
          if (tap_idx_q == LAST_TAP) begin
            state_d = ST_DONE;
          end else begin
            tap_idx_d = tap_idx_q + TAP_W'(1);
            state_d   = ST_ISSUE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          if (wait_cnt_d == WAIT_MAX) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    req_d  = (state_d == ST_ISSUE);
    poly_d = poly_q;
    if (state_d == ST_ISSUE) begin
      poly_d = coef_d[tap_idx_d];
    end
  end

  // State, counters, coefficient bank and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tap_idx_q  <= '0;
      wait_cnt_q <= '0;
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        coef_q[i] <= '0;
      end
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      poly_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_idx_q  <= tap_idx_d;
      wait_cnt_q <= wait_cnt_d;
      coef_q     <= coef_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      poly_q     <= poly_d;
      req_q      <= req_d;
    end
  end

  assign res_wdata_c = '{sel: sh_select_line, cnt: sh_shift_count, zero: sh_polynomial_zero};

  tap_result_bank #(
    .NUM_TAPS (NUM_TAPS),
    .TAP_W    (TAP_W)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (res_clr_c),
    .wr_en_i    (res_wr_c),
    .wr_addr_i  (tap_idx_q),
    .wr_data_i  (res_wdata_c),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_c),
    .rd_valid_o (rd_valid)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign sh_polynomial  = poly_q;
  assign sh_in_data_vld = req_q;
  assign rd_select_line = rd_data_c.sel;
  assign rd_shift_count = rd_data_c.cnt;
  assign rd_zero        = rd_data_c.zero;

endmodule

// File: tb/tb_fir_coef_scheduler.sv
// Bench for fir_coef_scheduler: shifter stub, pass-level model and a
// per-cycle compare of the handshake/status outputs.
module tb_fir_coef_scheduler;

  localparam int NT      = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       vld;
    logic [3:0] poly;
    logic       err;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       cfg_wr_en;
  logic [1:0] cfg_wr_addr;
  logic [3:0] cfg_wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] sh_polynomial;
  logic       sh_in_data_vld;
  logic [2:0] sh_select_line;
  logic       sh_select_line_vld;
  logic [1:0] sh_shift_count;
  logic       sh_polynomial_zero;
  logic [1:0] rd_addr;
  logic [2:0] rd_select_line;
  logic [1:0] rd_shift_count;
  logic       rd_zero;
  logic       rd_valid;

  fir_coef_scheduler #(.NUM_TAPS(NT), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_wr_addr        (cfg_wr_addr),
    .cfg_wr_data        (cfg_wr_data),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .sh_polynomial      (sh_polynomial),
    .sh_in_data_vld     (sh_in_data_vld),
    .sh_select_line     (sh_select_line),
    .sh_select_line_vld (sh_select_line_vld),
    .sh_shift_count     (sh_shift_count),
    .sh_polynomial_zero (sh_polynomial_zero),
    .rd_addr            (rd_addr),
    .rd_select_line     (rd_select_line),
    .rd_shift_count     (rd_shift_count),
    .rd_zero            (rd_zero),
    .rd_valid           (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [3:0] model_coef  [NT];
  logic [5:0] model_res   [NT];
  logic       model_valid [NT];
  obs_t       exp_q [$];
  logic [3:0] idle_poly = 4'h0;
  logic       idle_err  = 1'b0;
  bit         chk_en    = 1'b0;
  int         busy_cnt, done_cnt, vld_cnt;

  // Stub controls
  int         hang_tap  = -1;
  bit         stray_req = 1'b0;
  bit         stub_pend;
  int         stub_issue;
  int         stub_left;
  logic [5:0] stub_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shifter behaviour: rotate right until bit0 is set; {sel, count, zero}.
  function automatic logic [5:0] shf(input logic [3:0] c);
    logic [3:0] r;
    int k;
    if (c == 4'h0) return 6'b000_00_1;
    r = c;
    k = 0;
    while (r[0] == 1'b0) begin
      r = {r[0], r[3:1]};
      k++;
    end
    return {r[3:1], 2'(k), 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expand one pass into the expected per-cycle observation sequence.
  task automatic plan_pass(input int hang);
    obs_t       o;
    logic [5:0] r;
    logic [3:0] c;
    busy_cnt = 0;
    done_cnt = 0;
    vld_cnt  = 0;
    c = 4'h0;
    for (int t = 0; t < NT; t++) begin
      c = model_coef[t];
      r = shf(c);
      o = '{busy: 1'b1, done: 1'b0, vld: 1'b1, poly: c, err: 1'b0};
      exp_q.push_back(o);
      o.vld = 1'b0;
      if (t == hang) begin
        repeat (TIMEOUT) exp_q.push_back(o);
        o.done = 1'b1;
        o.err  = 1'b1;
        exp_q.push_back(o);
        idle_err  = 1'b1;
        idle_poly = c;
        for (int u = t; u < NT; u++) model_valid[u] = 1'b0;
        return;
      end
      repeat (int'(r[2:1]) + 1) exp_q.push_back(o);
      model_res[t]   = r;
      model_valid[t] = 1'b1;
    end
    o = '{busy: 1'b1, done: 1'b1, vld: 1'b0, poly: c, err: 1'b0};
    exp_q.push_back(o);
    idle_err  = 1'b0;
    idle_poly = c;
  endtask

  // Per-cycle compare of handshake/status outputs against the model.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (chk_en && !reset) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{busy: 1'b0, done: 1'b0, vld: 1'b0, poly: idle_poly, err: idle_err};
      a = '{busy: busy, done: done, vld: sh_in_data_vld, poly: sh_polynomial, err: error};
      check("cycle{busy,done,vld,poly,err}", 32'(a), 32'(e));
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (sh_in_data_vld) vld_cnt++;
    end
  end

  // Shifter stub: answers in WAIT cycle k+1, or never for hang_tap.
  always @(negedge clk) begin
    if (reset) begin
      stub_pend          = 1'b0;
      stub_issue         = 0;
      stub_left          = 0;
      sh_select_line_vld = 1'b0;
      sh_select_line     = 3'b000;
      sh_shift_count     = 2'b00;
      sh_polynomial_zero = 1'b0;
    end else begin
      if (!busy) stub_issue = 0;
      sh_select_line_vld = 1'b0;
      sh_select_line     = 3'b101;
      sh_shift_count     = 2'b10;
      sh_polynomial_zero = 1'b1;
      if (sh_in_data_vld) begin
        stub_res  = shf(sh_polynomial);
        stub_left = int'(stub_res[2:1]);
        stub_pend = (stub_issue != hang_tap);
        stub_issue++;
      end else if (stub_pend) begin
        if (stub_left == 0) begin
          sh_select_line_vld = 1'b1;
          {sh_select_line, sh_shift_count, sh_polynomial_zero} = stub_res;
          stub_pend = 1'b0;
        end else begin
          stub_left--;
        end
      end else if (stray_req) begin
        sh_select_line_vld = 1'b1;
        sh_select_line     = 3'b111;
        sh_shift_count     = 2'b11;
        sh_polynomial_zero = 1'b0;
      end
    end
  end

  task automatic write_coef(input logic [1:0] a, input logic [3:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    model_coef[a] = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("pass_ends", 32'(busy), 32'(0));
    check("plan_drained", exp_q.size(), 0);
  endtask

  task automatic run_pass(input bit wr, input logic [1:0] wa, input logic [3:0] wd,
                          input int hang, input bit busy_wr);
    hang_tap = hang;
    start    = 1'b1;
    if (wr) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = wa;
      cfg_wr_data = wd;
      model_coef[wa] = wd;
    end
    tick();
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    plan_pass(hang);
    check("start_clears_error", 32'(error), 32'(0));
    if (busy_wr) begin
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = 2'd1;
      cfg_wr_data = 4'b1111;
      tick();
      cfg_wr_en = 1'b0;
    end
    wait_idle();
  endtask

  task automatic read_tap(input int a, output logic [5:0] d, output logic v);
    rd_addr = 2'(a);
    tick();
    d = {rd_select_line, rd_shift_count, rd_zero};
    v = rd_valid;
  endtask

  task automatic read_all();
    logic [5:0] d;
    logic       v;
    for (int t = 0; t < NT; t++) begin
      read_tap(t, d, v);
      check($sformatf("rd_data[%0d]", t), 32'(d), 32'(model_res[t]));
      check($sformatf("rd_valid[%0d]", t), 32'(v), 32'(model_valid[t]));
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, done, error, sh_polynomial, sh_in_data_vld,
                 rd_select_line, rd_shift_count, rd_zero, rd_valid}, 32'(0));
  endtask

  task automatic clear_model();
    for (int t = 0; t < NT; t++) begin
      model_coef[t]  = 4'h0;
      model_res[t]   = 6'h0;
      model_valid[t] = 1'b0;
    end
    exp_q.delete();
    idle_poly = 4'h0;
    idle_err  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] d;
    logic       v;
    reset       = 1'b1;
    start       = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = 2'd0;
    cfg_wr_data = 4'h0;
    rd_addr     = 2'd0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Basic pass over {0101, 0110, 1000, 0000}
    write_coef(2'd0, 4'b0101);
    write_coef(2'd1, 4'b0110);
    write_coef(2'd2, 4'b1000);
    write_coef(2'd3, 4'b0000);
    run_pass(1'b0, 2'd0, 4'h0, -1, 1'b0);
    check("pass1_busy_cycles", busy_cnt, 13);
    check("pass1_done_pulses", done_cnt, 1);
    check("pass1_req_pulses", vld_cnt, 4);
    check("pass1_error", 32'(error), 32'(0));
    read_all();
    read_tap(0, d, v); check("tap0_lit", 32'(d), 32'(6'b010_00_0));
    read_tap(1, d, v); check("tap1_lit", 32'(d), 32'(6'b001_01_0));
    read_tap(2, d, v); check("tap2_lit", 32'(d), 32'(6'b000_11_0));
    read_tap(3, d, v); check("tap3_lit", 32'(d), 32'(6'b000_00_1));

    // Write with start lands first; write while busy is dropped
    run_pass(1'b1, 2'd0, 4'b0011, -1, 1'b1);
    check("pass2_busy_cycles", busy_cnt, 13);
    read_all();
    read_tap(0, d, v); check("same_cycle_wr_tap0", 32'(d), 32'(6'b001_00_0));
    read_tap(1, d, v); check("busy_wr_dropped_tap1", 32'(d), 32'(6'b001_01_0));

    // Shifter never answers tap2
    run_pass(1'b0, 2'd0, 4'h0, 2, 1'b0);
    check("hang_busy_cycles", busy_cnt, 22);
    check("hang_done_pulses", done_cnt, 1);
    check("hang_error", 32'(error), 32'(1));
    read_all();
    read_tap(0, d, v); check("hang_valid0", 32'(v), 32'(1));
    read_tap(1, d, v); check("hang_valid1", 32'(v), 32'(1));
    read_tap(2, d, v); check("hang_valid2", 32'(v), 32'(0));
    read_tap(3, d, v); check("hang_valid3", 32'(v), 32'(0));

    // Next start clears error, normal pass
    run_pass(1'b0, 2'd0, 4'h0, -1, 1'b0);
    check("recover_error", 32'(error), 32'(0));
    read_all();

    // Stray result valid while idle is ignored
    stray_req = 1'b1;
    repeat (3) tick();
    stray_req = 1'b0;
    tick();
    read_all();

    // Reset in the middle of WAIT
    write_coef(2'd0, 4'b1000);
    hang_tap = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    plan_pass(-1);
    tick();
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_all_zero("async_reset_mid_wait");
    clear_model();
    tick();
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    done_cnt = 0;
    repeat (4) tick();
    check("no_done_after_reset", done_cnt, 0);
    read_all();
    run_pass(1'b0, 2'd0, 4'h0, -1, 1'b0);
    check("cleared_coef_busy_cycles", busy_cnt, 9);
    read_all();
    read_tap(0, d, v); check("cleared_coef_tap0", 32'(d), 32'(6'b000_00_1));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
